// File: rtl/mem_seg_if.sv
// mem_seg_if: EX -> MEM -> WB bundle for the MEM pipeline stage.
//   in_valid / ALUo_in / B_in / IR_in : instruction presented by the EX stage
//   stall                             : EX must hold its outputs while high
//   out_valid / LMD / ALUo / IR       : registered results towards write-back
// master = EX/WB side, slave = mem_seg.
interface mem_seg_if;
    logic        in_valid;
    logic [31:0] ALUo_in;
    logic [31:0] B_in;
    logic [31:0] IR_in;
    logic        stall;
    logic        out_valid;
    logic [31:0] LMD;
    logic [31:0] ALUo;
    logic [31:0] IR;

    modport master (
        output in_valid, ALUo_in, B_in, IR_in,
        input  stall, out_valid, LMD, ALUo, IR
    );

    modport slave (
        input  in_valid, ALUo_in, B_in, IR_in,
        output stall, out_valid, LMD, ALUo, IR
    );
endinterface

// File: rtl/mem_seg.sv
// mem_seg: MEM pipeline stage with an internal word-addressed data RAM.
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset (RAM contents are kept)
//   bus  : mem_seg_if.slave -- EX inputs, stall, and registered WB outputs
// lw takes MEM_LAT edges from acceptance to LMD valid and stalls upstream
// meanwhile; sw and every other opcode complete in one edge.
//
// state | meaning
// IDLE  | accepting a new instruction whenever in_valid is high
// LOAD  | lw in flight; upstream stalled, bubbles issued until the count ends
module mem_seg #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input logic      clk,
    input logic      rst,
    mem_seg_if.slave bus
);
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_alu_lat;
    logic [31:0]       r_ir_lat;
    logic [31:0]       r_lmd;
    logic [31:0]       r_alu;
    logic [31:0]       r_ir;
    logic              r_out_valid;
    logic [31:0]       r_mem [2**ADDR_W];

    logic [ADDR_W-1:0] w_idx;
    logic              w_accept;
    logic              w_is_lw;
    logic              w_is_sw;

    // Byte offset bits and bits above the RAM depth are dropped: addresses wrap.
    assign w_idx    = bus.ALUo_in[ADDR_W+1:2];
    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_is_lw  = (bus.IR_in[31:26] == OP_LW);
    assign w_is_sw  = (bus.IR_in[31:26] == OP_SW);

    assign bus.stall     = (r_state == LOAD);
    assign bus.out_valid = r_out_valid;
    assign bus.LMD       = r_lmd;
    assign bus.ALUo      = r_alu;
    assign bus.IR        = r_ir;

    // RAM has no reset; a write is suppressed on a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && w_accept && w_is_sw) begin
            r_mem[w_idx] <= bus.B_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_alu_lat   <= '0;
            r_ir_lat    <= '0;
            r_lmd       <= '0;
            r_alu       <= '0;
            r_ir        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!bus.in_valid) begin
                        // bubble: IR cleared so write-back sees a NOP
                        r_ir        <= '0;
                        r_out_valid <= 1'b0;
                    end else if (w_is_lw && (MEM_LAT > 1)) begin
                        r_idx       <= w_idx;
                        r_alu_lat   <= bus.ALUo_in;
                        r_ir_lat    <= bus.IR_in;
                        r_cnt       <= CNT_INIT;
                        r_state     <= LOAD;
                        r_ir        <= '0;
                        r_out_valid <= 1'b0;
                    end else begin
                        if (w_is_lw) begin
                            r_lmd <= r_mem[w_idx];
                        end
                        r_alu       <= bus.ALUo_in;
                        r_ir        <= bus.IR_in;
                        r_out_valid <= 1'b1;
                    end
                end
                LOAD: begin
                    if (r_cnt == 4'd1) begin
                        r_lmd       <= r_mem[r_idx];
                        r_alu       <= r_alu_lat;
                        r_ir        <= r_ir_lat;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt       <= r_cnt - 4'd1;
                        r_ir        <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
